stopwatch_bcd_core: RTL and testbench
=====================================

# stopwatch_bcd_core

Parametrised stopwatch/timer core that counts directly in BCD over `DIGITS` digits, up or down, from zero, all-nines or a preset. It adds pause/resume, terminal detection, lap hold and clamping of invalid preset digits, and it drives a multiplexed common-anode seven-segment display. It replaces the old split of clock divider, state machine, datapath and binary-to-decimal conversion with one block. All timing is derived from a single clock, with no generated clocks and no division logic.

## Interface
- `DIGITS`, 4: number of BCD digits; legal range 2..8.
- `TICK_DIV`, 1_000_000: `clk` cycles per count tick; must be ≥1.
- `SCAN_DIV`, 100_000: `clk` cycles per display digit slot; must be ≥1.
- `DP_POS`, 2: digit index whose decimal point is lit; legal range 0..DIGITS-1.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  synchronous level; its rising edge is the start/stop/clear command.
- `lap`  in  1  synchronous level; its rising edge toggles lap hold.
- `mode`  in  2  bit0 sets direction (0 = up, 1 = down); bit1 sets load source (0 = default, 1 = `init`).
- `init`  in  4*DIGITS  BCD preset; digit 0 is in bits [3:0].
- `count`  out  4*DIGITS  live BCD count.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `lap_hold`  out  1  high while the display is frozen on a lap snapshot.
- `an`  out  DIGITS  active-low digit enables, one-hot.
- `sseg`  out  8  active-low segments, ordered {dp,g,f,e,d,c,b,a}.

## Operation
- **Edge detection:** `start` and `lap` each pass through a one-flop edge detector. An edge is a 0→1 transition seen between consecutive cycles.
- **State machine:** states are IDLE, RUN, PAUSE, DONE. A start edge moves IDLE→RUN, RUN→PAUSE, PAUSE→RUN and DONE→IDLE.
- **Load value:**
  - mode[1]=1 loads `init`, with any digit >9 clamped to 9.
  - mode[1]=0 loads zero when counting up and all-nines when counting down.
- **Preset tracking in IDLE:** `count` reloads the load value every cycle, so the display tracks the preset.
- **Mode sampling:** `mode` is latched on the IDLE→RUN transition. Changes to `mode` in RUN, PAUSE or DONE are ignored.
- **Prescaler:**
  - Counts 0..TICK_DIV-1 while in RUN and is cleared on IDLE→RUN.
  - Holds its value in PAUSE, so the partial tick is preserved across a pause.
  - A tick fires in any RUN cycle where the prescaler equals TICK_DIV-1.
- **Counting:**
  - On a tick the count steps by ±1 in BCD: digit carry at 9→0 when counting up, digit borrow at 0→9 when counting down.
  - There is no wrap. When a tick makes the count reach its terminal value (all-nines for up, zero for down), the state goes to DONE on the same edge and `count` holds the terminal value.
  - Starting in a state where the count is already terminal gives RUN→DONE on the first tick, with the count unchanged.
- **Lap hold:**
  - A lap edge in RUN or PAUSE toggles `lap_hold`. On the 0→1 toggle, `count` is snapshotted into the lap register.
  - While `lap_hold`=1 the display shows the snapshot and `count` continues to run.
  - Entering IDLE clears `lap_hold`. A lap edge in IDLE or DONE is ignored.
- **Simultaneous events:**
  - A start edge and a lap edge in the same cycle: start is processed and lap is ignored.
  - A tick and a start edge in RUN in the same cycle: the count steps and the state goes to PAUSE.
- **Display scan:**
  - A scan counter of SCAN_DIV cycles advances the digit index 0→DIGITS-1→0 continuously in every state.
  - The displayed digit is `an[i]`=0 for the current index, showing that digit of `count`, or of the snapshot when `lap_hold`=1.
  - dp (sseg[7]) is 0 only when the index equals DP_POS.
- **Segment encoding** (bits [6:0], active-low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, shown here as the full byte with dp off.

## Timing
- **Reset (rst=0, asynchronous):**
  - state IDLE, `count`=0, prescaler 0, scan counter 0, index 0.
  - `running`=0, `done`=0, `lap_hold`=0.
  - `an` all ones, `sseg`=8'hFF.
- **After reset release:** on the first clock edge `count` loads the load value.
- **Command latency:** a start level rising before edge k is detected at edge k. The state changes at edge k+1; `running` and `done` are registered from the state.
- **Count latency:** `count` updates on the tick edge itself, with no extra latency.
- **Display latency:** `an` and `sseg` are registered and change one cycle after the index or data changes. Display blanking occurs only in reset.

## Test plan
- **Up count to terminal:** DIGITS=2, TICK_DIV=4, mode=00, start pulse → `count` goes 00→01 four cycles after RUN is entered; reaches 99 after 396 RUN cycles; then `done`=1, `running`=0, and `count` holds 99 for 50 more cycles.
- **Down from preset:** mode=11, init=8'h05, start → `count` 05,04,…,00 with one step every 4 cycles; `done`=1 at 00. A further start edge → IDLE with `count`=05.
- **Pause and resume:** pause 2 cycles into a tick period, wait 20 cycles → `count` unchanged. Resume → next step occurs exactly 2 cycles later.
- **Lap hold:** lap at `count`=8'h12 → display digits show 1 and 2 (sseg A4/F9 with dp rules) while `count` advances to 8'h15. A second lap edge → display shows the live value.
- **Invalid preset and mode change:** init=8'hA3, mode=10 → loads 8'h93. Toggling mode during RUN does not change the direction.
- **Reset mid-run:** drive `rst` low mid-run → `count`=0, `an`=2'b11, `sseg`=8'hFF before the next clk edge. After release, state is IDLE and the display shows the preset, scanning at SCAN_DIV=2.

Source files
------------

// File: rtl/stopwatch_bcd_core.sv
// stopwatch_bcd_core
// BCD stopwatch/timer core. It counts up or down over DIGITS BCD digits,
// starting from zero, all-nines or a clamped preset. It supports pause/resume,
// terminal detection and lap hold, and it drives a multiplexed common-anode
// seven-segment display.
//
// Ports:
//   clk       system clock (only clock)
//   rst       asynchronous active-low reset
//   start     level; rising edge = start / pause / resume / clear
//   lap       level; rising edge toggles lap hold (RUN or PAUSE only)
//   mode      bit0 direction (0 up, 1 down), bit1 load source (1 = init)
//   init      BCD preset, digit 0 in bits [3:0]
//   count     live BCD count
//   running   high in RUN
//   done      high in DONE
//   lap_hold  high while the display shows the lap snapshot
//   an        active-low one-hot digit enables
//   sseg      active-low segments {dp,g,f,e,d,c,b,a}
`timescale 1ns/1ps
module stopwatch_bcd_core #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1_000_000,
    parameter int SCAN_DIV = 100_000,
    parameter int DP_POS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  lap,
    input  logic [1:0]            mode,
    input  logic [4*DIGITS-1:0]   init,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  done,
    output logic                  lap_hold,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            sseg
);

    localparam int CW = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] ALL_NINES = {DIGITS{4'h9}};
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [IW-1:0] IDX_DP    = IW'(DP_POS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t          state_q, state_d;
    logic            start_prev_q, start_evt_q;
    logic            lap_prev_q, lap_evt_q;
    logic            down_q, down_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   lap_val_q, lap_val_d;
    logic            lap_hold_q, lap_hold_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [SW-1:0]   scan_q;
    logic [IW-1:0]   idx_q;
    logic            running_q, done_q;
    logic [DIGITS-1:0] an_q;
    logic [7:0]      sseg_q;

    logic [CW-1:0]   load_val, step_val, terminal_val, disp_src;
    logic [3:0]      disp_digit;
    logic            tick;

    // One BCD step across all digits; carry/borrow ripples from digit 0.
    function automatic logic [CW-1:0] bcd_step(input logic [CW-1:0] v, input logic down);
        logic [CW-1:0] r;
        logic          c;
        logic [3:0]    d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (!down) begin
                    if (d == 4'd9) begin r[4*i +: 4] = 4'd0; c = 1'b1; end
                    else begin r[4*i +: 4] = d + 4'd1; c = 1'b0; end
                end else begin
                    if (d == 4'd0) begin r[4*i +: 4] = 4'd9; c = 1'b1; end
                    else begin r[4*i +: 4] = d - 4'd1; c = 1'b0; end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] clamp_bcd(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Load value follows the live mode so IDLE tracks the preset.
    assign load_val     = mode[1] ? clamp_bcd(init) : (mode[0] ? ALL_NINES : '0);
    assign terminal_val = down_q ? '0 : ALL_NINES;
    assign step_val     = bcd_step(count_q, down_q);
    assign tick         = (state_q == S_RUN) && (presc_q == TICK_LAST);
    assign disp_src     = lap_hold_q ? lap_val_q : count_q;
    assign disp_digit   = disp_src[4*idx_q +: 4];

    always_comb begin
        state_d    = state_q;
        down_d     = down_q;
        count_d    = count_q;
        lap_val_d  = lap_val_q;
        lap_hold_d = lap_hold_q;
        presc_d    = presc_q;
        case (state_q)
            S_IDLE: begin
                count_d    = load_val;
                lap_hold_d = 1'b0;
                if (start_evt_q) begin
                    state_d = S_RUN;
                    down_d  = mode[0];
                    presc_d = '0;
                end
            end
            S_RUN: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    // Already terminal: finish without stepping (no wrap).
                    if (count_q == terminal_val) begin
                        state_d = S_DONE;
                    end else begin
                        count_d = step_val;
                        if (step_val == terminal_val) state_d = S_DONE;
                    end
                end
                // Start wins over both a terminal tick and a lap edge.
                if (start_evt_q) begin
                    state_d = S_PAUSE;
                end else if (lap_evt_q) begin
                    lap_hold_d = ~lap_hold_q;
                    if (!lap_hold_q) lap_val_d = count_q;
                end
            end
            S_PAUSE: begin
                if (start_evt_q) begin
                    state_d = S_RUN;
                end else if (lap_evt_q) begin
                    lap_hold_d = ~lap_hold_q;
                    if (!lap_hold_q) lap_val_d = count_q;
                end
            end
            S_DONE: begin
                if (start_evt_q) begin
                    state_d    = S_IDLE;
                    count_d    = load_val;
                    lap_hold_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            start_evt_q  <= 1'b0;
            lap_prev_q   <= 1'b0;
            lap_evt_q    <= 1'b0;
            down_q       <= 1'b0;
            count_q      <= '0;
            lap_val_q    <= '0;
            lap_hold_q   <= 1'b0;
            presc_q      <= '0;
            scan_q       <= '0;
            idx_q        <= '0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            an_q         <= '1;
            sseg_q       <= 8'hFF;
        end else begin
            start_prev_q <= start;
            start_evt_q  <= start & ~start_prev_q;
            lap_prev_q   <= lap;
            lap_evt_q    <= lap & ~lap_prev_q;
            state_q      <= state_d;
            down_q       <= down_d;
            count_q      <= count_d;
            lap_val_q    <= lap_val_d;
            lap_hold_q   <= lap_hold_d;
            presc_q      <= presc_d;
            running_q    <= (state_d == S_RUN);
            done_q       <= (state_d == S_DONE);
            if (scan_q == SCAN_LAST) begin
                scan_q <= '0;
                idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                scan_q <= scan_q + 1'b1;
            end
            an_q   <= ~(DIGITS'(1) << idx_q);
            sseg_q <= {(idx_q != IDX_DP), seg7(disp_digit)};
        end
    end

    assign count    = count_q;
    assign running  = running_q;
    assign done     = done_q;
    assign lap_hold = lap_hold_q;
    assign an       = an_q;
    assign sseg     = sseg_q;

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
`timescale 1ns/1ps
module tb_stopwatch_bcd_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       lap;
  logic [1:0] mode;
  logic [7:0] init;
  logic [7:0] count;
  logic       running;
  logic       done;
  logic       lap_hold;
  logic [1:0] an;
  logic [7:0] sseg;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_seg;
  logic [1:0] exp_an;

  stopwatch_bcd_core #(
    .DIGITS(2), .TICK_DIV(4), .SCAN_DIV(2), .DP_POS(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .lap(lap), .mode(mode), .init(init),
    .count(count), .running(running), .done(done), .lap_hold(lap_hold),
    .an(an), .sseg(sseg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks (called at a negedge, return at a negedge)
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles(1);
  endtask

  task automatic press_lap();
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    cycles(1);
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  initial begin
    rst = 1'b0; start = 1'b0; lap = 1'b0; mode = 2'b00; init = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_count", count, 8'h00);
    check("rst_running", running, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_lap_hold", lap_hold, 1'b0);
    check("rst_an", an, 2'b11);
    check("rst_sseg", sseg, 8'hFF);
    rst = 1'b1;
    cycles(1);
    check("load_up_zero", count, 8'h00);

    // up count to terminal
    press_start();
    check("up_running", running, 1'b1);
    for (int i = 1; i <= 99; i++) exp_q.push_back(to_bcd(i));
    for (int i = 1; i <= 99; i++) begin
      cycles(3);
      check("up_hold", count, to_bcd(i - 1));
      cycles(1);
      check("up_step", count, exp_q.pop_front());
    end
    check("up_done", done, 1'b1);
    check("up_not_running", running, 1'b0);
    cycles(50);
    check("up_terminal_hold", count, 8'h99);
    check("up_done_hold", done, 1'b1);

    // clear, then down from preset
    press_start();
    check("clear_count", count, 8'h00);
    mode = 2'b11; init = 8'h05;
    cycles(1);
    check("preset_track", count, 8'h05);
    press_start();
    for (int i = 4; i >= 0; i--) exp_q.push_back(to_bcd(i));
    for (int i = 0; i < 5; i++) begin
      cycles(4);
      check("down_step", count, exp_q.pop_front());
    end
    check("down_done", done, 1'b1);
    press_start();
    check("down_clear_count", count, 8'h05);
    check("down_clear_done", done, 1'b0);

    // pause and resume
    mode = 2'b00;
    cycles(1);
    check("pause_load", count, 8'h00);
    press_start();
    cycles(4);
    check("pause_first", count, 8'h01);
    press_start();
    check("pause_running", running, 1'b0);
    cycles(20);
    check("pause_hold", count, 8'h01);
    press_start();
    check("resume_running", running, 1'b1);
    cycles(1);
    check("resume_early", count, 8'h01);
    cycles(1);
    check("resume_step", count, 8'h02);

    // lap hold
    cycles(40);
    check("lap_count", count, 8'h12);
    press_lap();
    check("lap_on", lap_hold, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycles(1);
      exp_seg = (an == 2'b01) ? 8'h79 : 8'hA4;
      check("lap_an_onehot", 32'((an == 2'b01) || (an == 2'b10)), 32'd1);
      check("lap_sseg", sseg, exp_seg);
    end
    cycles(2);
    check("lap_live_count", count, 8'h15);
    check("lap_still_on", lap_hold, 1'b1);
    press_lap();
    check("lap_off", lap_hold, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cycles(1);
      exp_seg = (an == 2'b01) ? 8'h79 : 8'h92;
      check("live_sseg", sseg, exp_seg);
    end

    // reset mid-run, asynchronous
    #2 rst = 1'b0;
    #1;
    check("arst_count", count, 8'h00);
    check("arst_an", an, 2'b11);
    check("arst_sseg", sseg, 8'hFF);
    check("arst_running", running, 1'b0);
    check("arst_lap_hold", lap_hold, 1'b0);
    @(negedge clk);
    init = 8'hA3; mode = 2'b10; rst = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      cycles(1);
      exp_an = (((n - 1) / 2) % 2 == 1) ? 2'b01 : 2'b10;
      exp_seg = (exp_an == 2'b01) ? 8'h10 : 8'hB0;
      check("scan_an", an, exp_an);
      if (n >= 2) check("scan_sseg", sseg, exp_seg);
      if (n == 1) begin
        check("clamp_load", count, 8'h93);
        check("post_rst_idle", running, 1'b0);
      end
    end

    // mode change during RUN ignored
    press_start();
    mode = 2'b11;
    for (int i = 94; i <= 99; i++) exp_q.push_back(to_bcd(i));
    for (int i = 0; i < 6; i++) begin
      cycles(4);
      check("mode_lock_step", count, exp_q.pop_front());
    end
    check("mode_lock_done", done, 1'b1);
    press_lap();
    check("lap_in_done_ignored", lap_hold, 1'b0);
    press_start();
    check("clear_clamped", count, 8'h93);

    // already terminal at start
    init = 8'h99; mode = 2'b10;
    cycles(1);
    check("term_preset", count, 8'h99);
    press_start();
    cycles(3);
    check("term_running", running, 1'b1);
    check("term_count", count, 8'h99);
    cycles(1);
    check("term_done", done, 1'b1);
    check("term_count_hold", count, 8'h99);

    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
